// File: rtl/noc_router_pkg.sv
// Shared types for the NoC router output stage.
package noc_router_pkg;

  // Per-VC output FSM: waiting for a request, or holding a packet lock.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } vc_state_t;

endpackage

// File: rtl/noc_arb_rr.sv
// Round-robin picker: first set req bit strictly after ptr, wrapping.
module noc_arb_rr #(
  parameter int N = 2
) (
  input  logic [N-1:0]                 req,
  input  logic [$clog2(N>1?N:2)-1:0]   ptr,
  output logic [N-1:0]                 gnt,
  output logic [$clog2(N>1?N:2)-1:0]   idx
);
  localparam int W = $clog2(N>1?N:2);

  int  c;
  logic found;

  // Scan N positions starting at ptr+1; the first request seen wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = W'(c);
      end
    end
  end

endmodule

// File: rtl/noc_router_output_arbiter.sv
// Output-port arbiter: per-VC packet locking onto one input, then a
// cycle-by-cycle VC round-robin onto the shared output flit bus.
module noc_router_output_arbiter import noc_router_pkg::*; #(
  parameter int FLIT_WIDTH = 32,
  parameter int VCHANNELS  = 1,
  parameter int INPUTS     = 5
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [VCHANNELS-1:0][INPUTS-1:0][FLIT_WIDTH-1:0] in_flit,
  input  logic [VCHANNELS-1:0][INPUTS-1:0]              in_last,
  input  logic [VCHANNELS-1:0][INPUTS-1:0]              in_valid,
  output logic [VCHANNELS-1:0][INPUTS-1:0]              in_ready,
  output logic [FLIT_WIDTH-1:0]                         out_flit,
  output logic                                          out_last,
  output logic [VCHANNELS-1:0]                          out_valid,
  input  logic [VCHANNELS-1:0]                          out_ready
);
  localparam int IW = $clog2(INPUTS>1?INPUTS:2);
  localparam int VW = $clog2(VCHANNELS>1?VCHANNELS:2);

  vc_state_t [VCHANNELS-1:0]         state;
  logic      [VCHANNELS-1:0][IW-1:0] grant;
  logic      [VCHANNELS-1:0][IW-1:0] in_ptr;
  logic      [VW-1:0]                vc_ptr;

  logic [INPUTS-1:0] in_gnt  [VCHANNELS];
  logic [IW-1:0]     win_idx [VCHANNELS];
  logic [VCHANNELS-1:0] elig;
  logic [VCHANNELS-1:0] vc_gnt;
  logic [VW-1:0]        vc_idx;
  logic                 xfer;

  // One input arbiter per VC; only consulted while that VC is IDLE.
  for (genvar v = 0; v < VCHANNELS; v++) begin : g_vc
    noc_arb_rr #(.N(INPUTS)) u_in_arb (
      .req (in_valid[v]),
      .ptr (in_ptr[v]),
      .gnt (in_gnt[v]),
      .idx (win_idx[v])
    );
    assign elig[v] = (state[v] == LOCKED) && in_valid[v][grant[v]] && out_ready[v];
  end

  noc_arb_rr #(.N(VCHANNELS)) u_vc_arb (
    .req (elig),
    .ptr (vc_ptr),
    .gnt (vc_gnt),
    .idx (vc_idx)
  );

  assign xfer      = |vc_gnt;
  // Outputs are gated by reset so they drop in the same cycle reset asserts.
  assign out_valid = rst ? vc_gnt : '0;
  assign out_flit  = in_flit[vc_idx][grant[vc_idx]];
  assign out_last  = rst && xfer && in_last[vc_idx][grant[vc_idx]];

  // Ready back only to the locked input of the chosen VC.
  always_comb begin
    in_ready = '0;
    for (int v = 0; v < VCHANNELS; v++)
      for (int i = 0; i < INPUTS; i++)
        if (vc_gnt[v] && grant[v] == IW'(i)) in_ready[v][i] = rst;
  end

  // Per-VC lock FSM plus input/VC round-robin pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VCHANNELS; v++) begin
        state[v]  <= IDLE;
        grant[v]  <= '0;
        in_ptr[v] <= IW'(INPUTS-1);
      end
      vc_ptr <= VW'(VCHANNELS-1);
    end else begin
      for (int v = 0; v < VCHANNELS; v++) begin
        case (state[v])
          IDLE: if (|in_gnt[v]) begin
            grant[v] <= win_idx[v];
            state[v] <= LOCKED;
          end
          LOCKED: if (vc_gnt[v] && in_last[v][grant[v]]) begin
            state[v]  <= IDLE;
            in_ptr[v] <= grant[v];
          end
          default: state[v] <= IDLE;
        endcase
      end
      if (xfer) vc_ptr <= vc_idx;
    end
  end

endmodule

// File: doc/noc_router_output_arbiter.md
NOC_ROUTER_OUTPUT_ARBITER -- requirements
Module: noc_router_output_arbiter

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 32, flit data width.
REQ-002 SHALL have parameter VCHANNELS, default 1, number of virtual channels on the output link.
REQ-003 SHALL have parameter INPUTS, default 5, number of router input ports competing for this output.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_flit  input  [VCHANNELS][INPUTS][FLIT_WIDTH]  flit offered by each input's VC.
REQ-007 SHALL have port in_last  input  [VCHANNELS][INPUTS]  last flit of packet.
REQ-008 SHALL have port in_valid  input  [VCHANNELS][INPUTS]  request toward this output.
REQ-009 SHALL have port in_ready  output  [VCHANNELS][INPUTS]  flit accepted.
REQ-010 SHALL have port out_flit  output  [FLIT_WIDTH]  shared link flit bus.
REQ-011 SHALL have port out_last  output  1  last flag of the flit on out_flit.
REQ-012 SHALL have port out_valid  output  [VCHANNELS]  per-VC valid, at most one bit set.
REQ-013 SHALL have port out_ready  input  [VCHANNELS]  per-VC downstream ready; must not depend combinationally on out_valid.

Function
REQ-014 Each VC SHALL own an FSM with states IDLE and LOCKED, plus a grant register (input index) and a round-robin pointer.
REQ-015 IDLE with any in_valid[v] set: SHALL select a winner by round-robin starting at pointer+1 (wrapping at INPUTS-1 -> 0), register it, go LOCKED next cycle; no transfer occurs in the IDLE cycle.
REQ-016 IDLE with no request: SHALL stay IDLE; pointer unchanged.
REQ-017 LOCKED: VC v SHALL be eligible when in_valid[v][grant] is 1 and out_ready[v] is 1.
REQ-018 Per cycle, exactly one eligible VC SHALL be chosen by a VC round-robin pointer (first eligible after the last VC that transferred); none eligible -> out_valid all zero.
REQ-019 For chosen VC v: out_valid[v]=1, out_flit/out_last = in_flit/in_last[v][grant], in_ready[v][grant]=1; all other in_ready SHALL be 0.
REQ-020 Datapath SHALL be combinational: zero added latency in LOCKED; out_flit is don't-care when out_valid is zero.
REQ-021 A transfer with in_last=1 SHALL return that VC to IDLE, set its input pointer to grant, and set the VC pointer to v.
REQ-022 Packets SHALL never interleave within one VC; flits of different VCs MAY interleave cycle by cycle.
REQ-023 A granted input deasserting in_valid mid-packet SHALL keep the lock; the VC waits without timeout.
REQ-024 INPUTS=1 or VCHANNELS=1 SHALL work with degenerate pointers (always index 0).

Reset
REQ-025 rst low SHALL asynchronously force every FSM to IDLE, grant to 0, input pointers to INPUTS-1, VC pointer to VCHANNELS-1.
REQ-026 Under reset, out_valid and in_ready SHALL be 0; out_last SHALL be 0.
REQ-027 Reset mid-packet SHALL abandon the packet without recovery; after release, input 0 and VC 0 have first priority.

Structure
REQ-028 The FSM state typedef (IDLE, LOCKED) SHALL live in shared package noc_router_pkg.
REQ-029 Round-robin selection SHALL be sub-module noc_arb_rr (parameter N; req, ptr -> one-hot gnt, index), instantiated VCHANNELS times for inputs and once for VCs.

Verification (INPUTS=5, VCHANNELS=2, FLIT_WIDTH=32)
REQ-030 After reset, input 2 VC0 sends 3-flit packet, out_ready=2'b11 -> cycle 0 arbitration, flits on cycles 1-3 with out_valid=2'b01, out_last only on cycle 3.
REQ-031 Inputs 0 and 3 VC0 each offer 2-flit packets at once -> input 0 completes fully, one idle cycle, then input 3; never interleaved.
REQ-032 Inputs 1 and 4 VC0 continuously offer 1-flit packets -> grant order 1,4,1,4.
REQ-033 VC0 locked on input 0, VC1 locked on input 1, both ready -> out_valid alternates 2'b01, 2'b10 each cycle.
REQ-034 Both VCs locked, out_ready=2'b10 -> only VC1 transfers; in_ready[0][*]=0; VC0 flit held by source resumes when out_ready[0]=1.
REQ-035 rst low after 2 of 4 flits from input 3 -> out_valid=0 same cycle; after release, new requests on inputs 0 and 3 -> input 0 wins.
